// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: D = A - B - Bin, one full-subtractor step per clock, LSB first.
// A start/busy/done handshake sequences operations; d/bout hold the last completed result.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CW-1:0]    count_q, count_d;
    logic             brw_q, brw_d;
    logic             bout_q, bout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             diff_bit;
    logic             borrow_next;
    logic             last_bit;

    always_comb begin
        diff_bit    = sa_q[0] ^ sb_q[0] ^ brw_q;
        borrow_next = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & brw_q);
        last_bit    = (count_q == CW'(WIDTH - 1));

        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        res_d   = res_q;
        d_d     = d_q;
        count_d = count_q;
        brw_d   = brw_q;
        bout_d  = bout_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    brw_d   = bin;
                    res_d   = '0;
                    count_d = '0;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                // Difference bits enter at the MSB so that after WIDTH steps
                // the first (LSB) bit has walked down to position 0.
                res_d   = {diff_bit, res_q[WIDTH-1:1]};
                sa_d    = sa_q >> 1;
                sb_d    = sb_q >> 1;
                brw_d   = borrow_next;
                count_d = count_q + CW'(1);
                if (last_bit) begin
                    d_d     = {diff_bit, res_q[WIDTH-1:1]};
                    bout_d  = borrow_next;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            res_q   <= '0;
            d_q     <= '0;
            count_q <= '0;
            brw_q   <= 1'b0;
            bout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            res_q   <= res_d;
            d_q     <= d_d;
            count_q <= count_d;
            brw_q   <= brw_d;
            bout_q  <= bout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign d    = d_q;
    assign bout = bout_q;

endmodule
